// File: rtl/exec_decode_unit_if.sv
// Instruction/operand bundle into the decode-execute stage and its decoded/executed outputs.
// Master drives the instruction, operands and PC; slave returns decode, ALU result, branch and flags.
interface exec_decode_unit_if;
  logic [15:0] operation;
  logic [15:0] input1;
  logic [15:0] input2;
  logic [15:0] pc;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [7:0]  ctrl_signals;
  logic [15:0] result;
  logic        br;
  logic        Z;
  logic        N;
  logic        V;

  modport master (
    output operation, input1, input2, pc,
    input  rd, rs, rt, ctrl_signals, result, br, Z, N, V
  );

  modport slave (
    input  operation, input1, input2, pc,
    output rd, rs, rt, ctrl_signals, result, br, Z, N, V
  );
endinterface

// File: rtl/exec_decode_unit.sv
// Decode/execute/branch-resolve stage of the 16-bit CPU; only state is the Z/N/V flag register.
// Zero latency (outputs combinational from inputs and flags); no backpressure, one instruction per cycle.
module exec_decode_unit (
  input  logic               clk,
  input  logic               rst_n,
  exec_decode_unit_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_PADDSB = 4'h1,
    OP_SUB    = 4'h2,
    OP_AND    = 4'h3,
    OP_NOR    = 4'h4,
    OP_SLL    = 4'h5,
    OP_SRL    = 4'h6,
    OP_SRA    = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LHB    = 4'hA,
    OP_LLB    = 4'hB,
    OP_B      = 4'hC,
    OP_JAL    = 4'hD,
    OP_JR     = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  opcode_e     opc;
  logic [3:0]  f_rd;
  logic [3:0]  f_rs;
  logic [3:0]  f_rt;
  logic [7:0]  imm8;
  logic [2:0]  cond;
  logic [15:0] a;
  logic [15:0] b;

  assign opc  = opcode_e'(bus.operation[15:12]);
  assign f_rd = bus.operation[11:8];
  assign f_rs = bus.operation[7:4];
  assign f_rt = bus.operation[3:0];
  assign imm8 = bus.operation[7:0];
  assign cond = bus.operation[11:9];
  assign a    = bus.input1;
  assign b    = bus.input2;

  // Saturating arithmetic: overflow when operand signs permit it and the result sign flips.
  logic [15:0] add_raw;
  logic [15:0] sub_raw;
  logic        add_ovf;
  logic        sub_ovf;
  logic [15:0] add_sat;
  logic [15:0] sub_sat;
  logic [7:0]  hi_raw;
  logic [7:0]  lo_raw;
  logic [7:0]  hi_sat;
  logic [7:0]  lo_sat;

  assign add_raw = a + b;
  assign sub_raw = a - b;
  assign add_ovf = (a[15] == b[15]) && (add_raw[15] != a[15]);
  assign sub_ovf = (a[15] != b[15]) && (sub_raw[15] != a[15]);
  assign add_sat = add_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : add_raw;
  assign sub_sat = sub_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : sub_raw;

  assign hi_raw = a[15:8] + b[15:8];
  assign lo_raw = a[7:0] + b[7:0];
  assign hi_sat = ((a[15] == b[15]) && (hi_raw[7] != a[15])) ? (a[15] ? 8'h80 : 8'h7F) : hi_raw;
  assign lo_sat = ((a[7] == b[7]) && (lo_raw[7] != a[7])) ? (a[7] ? 8'h80 : 8'h7F) : lo_raw;

  logic [15:0] result_c;
  logic [7:0]  ctrl_c;
  logic [3:0]  rd_c;
  logic [3:0]  rs_c;
  logic [3:0]  rt_c;
  logic        wr_znv;
  logic        wr_z;
  logic        ovf_c;

  always_comb begin
    result_c = 16'h0000;
    ctrl_c   = 8'h00;
    rd_c     = f_rd;
    rs_c     = f_rs;
    rt_c     = f_rt;
    wr_znv   = 1'b0;
    wr_z     = 1'b0;
    ovf_c    = 1'b0;
    case (opc)
      OP_ADD: begin
        result_c = add_sat;
        ovf_c    = add_ovf;
        ctrl_c   = 8'h01;
        wr_znv   = 1'b1;
      end
      OP_PADDSB: begin
        result_c = {hi_sat, lo_sat};
        ctrl_c   = 8'h01;
      end
      OP_SUB: begin
        result_c = sub_sat;
        ovf_c    = sub_ovf;
        ctrl_c   = 8'h01;
        wr_znv   = 1'b1;
      end
      OP_AND: begin
        result_c = a & b;
        ctrl_c   = 8'h01;
        wr_z     = 1'b1;
      end
      OP_NOR: begin
        result_c = ~(a | b);
        ctrl_c   = 8'h01;
        wr_z     = 1'b1;
      end
      OP_SLL: begin
        result_c = a << f_rt;
        ctrl_c   = 8'h01;
        wr_z     = 1'b1;
      end
      OP_SRL: begin
        result_c = a >> f_rt;
        ctrl_c   = 8'h01;
        wr_z     = 1'b1;
      end
      OP_SRA: begin
        result_c = $signed(a) >>> f_rt;
        ctrl_c   = 8'h01;
        wr_z     = 1'b1;
      end
      OP_LW: begin
        result_c = a + {{12{f_rt[3]}}, f_rt};
        ctrl_c   = 8'h83;
      end
      OP_SW: begin
        // Store data comes from the register named in the rd field.
        result_c = a + {{12{f_rt[3]}}, f_rt};
        ctrl_c   = 8'h04;
        rt_c     = f_rd;
      end
      OP_LHB: begin
        result_c = {imm8, a[7:0]};
        ctrl_c   = 8'h01;
        rs_c     = f_rd;
      end
      OP_LLB: begin
        result_c = {{8{imm8[7]}}, imm8};
        ctrl_c   = 8'h01;
      end
      OP_B: begin
        ctrl_c   = 8'h40;
      end
      OP_JAL: begin
        result_c = bus.pc + 16'd1;
        ctrl_c   = 8'h11;
        rd_c     = 4'hF;
      end
      OP_JR: begin
        result_c = a;
        ctrl_c   = 8'h20;
      end
      OP_HLT: begin
        ctrl_c   = 8'h08;
      end
    endcase
  end

  logic flag_z;
  logic flag_n;
  logic flag_v;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (wr_znv) begin
      flag_z <= (result_c == 16'h0000);
      flag_n <= result_c[15];
      flag_v <= ovf_c;
    end else if (wr_z) begin
      flag_z <= (result_c == 16'h0000);
    end
  end

  // Branch resolves against flags left by earlier instructions, never this cycle's result.
  logic cond_true;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000: cond_true = ~flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = ~flag_z & ~flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = ~flag_n;
      3'b101: cond_true = flag_n | flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
    endcase
  end

  assign bus.rd           = rd_c;
  assign bus.rs           = rs_c;
  assign bus.rt           = rt_c;
  assign bus.ctrl_signals = ctrl_c;
  assign bus.result       = result_c;
  assign bus.br           = (opc == OP_B) && cond_true;
  assign bus.Z            = flag_z;
  assign bus.N            = flag_n;
  assign bus.V            = flag_v;

endmodule

// File: tb/tb_exec_decode_unit.sv
// Scoreboard bench for exec_decode_unit: expected outputs queued at drive time, compared mid-cycle.
module tb_exec_decode_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  exec_decode_unit_if bus ();

  exec_decode_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] res;
    logic [7:0]  ctrl;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        br;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mz, mn, mv;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int s);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic [7:0] sat8(input int s);
    if (s > 127)  return 8'h7F;
    if (s < -128) return 8'h80;
    return s[7:0];
  endfunction

  function automatic logic [7:0] ctrl_of(input logic [3:0] opc);
    case (opc)
      4'h8:    return 8'h83;
      4'h9:    return 8'h04;
      4'hC:    return 8'h40;
      4'hD:    return 8'h11;
      4'hE:    return 8'h20;
      4'hF:    return 8'h08;
      default: return 8'h01;
    endcase
  endfunction

  // kres >= 0 pins the expected result to a hand-derived constant.
  task automatic step(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] p, input int kres = -1);
    exp_t        e;
    exp_t        got;
    int          sa, sb, raw, t, ha, hb, la, lb;
    logic [15:0] r;
    logic [3:0]  opc;
    logic        c;

    bus.operation = op;
    bus.input1    = a;
    bus.input2    = b;
    bus.pc        = p;

    opc = op[15:12];
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    raw = 0;
    r   = 16'h0000;
    case (opc)
      4'h0: begin raw = sa + sb; r = sat16(raw); end
      4'h1: begin
        ha = int'($signed(a[15:8])); hb = int'($signed(b[15:8]));
        la = int'($signed(a[7:0]));  lb = int'($signed(b[7:0]));
        r  = {sat8(ha + hb), sat8(la + lb)};
      end
      4'h2: begin raw = sa - sb; r = sat16(raw); end
      4'h3: r = a & b;
      4'h4: r = ~(a | b);
      4'h5: r = a << op[3:0];
      4'h6: r = a >> op[3:0];
      4'h7: begin t = sa >>> op[3:0]; r = t[15:0]; end
      4'h8, 4'h9: begin t = sa + int'($signed(op[3:0])); r = t[15:0]; end
      4'hA: r = {op[7:0], a[7:0]};
      4'hB: begin t = int'($signed(op[7:0])); r = t[15:0]; end
      4'hD: r = p + 16'd1;
      4'hE: r = a;
      default: r = 16'h0000;
    endcase

    case (op[11:9])
      3'd0: c = !mz;
      3'd1: c = mz;
      3'd2: c = !mz && !mn;
      3'd3: c = mn;
      3'd4: c = !mn;
      3'd5: c = mn || mz;
      3'd6: c = mv;
      default: c = 1'b1;
    endcase

    e.res  = (kres >= 0) ? kres[15:0] : r;
    e.ctrl = ctrl_of(opc);
    e.rd   = (opc == 4'hD) ? 4'hF : op[11:8];
    e.rs   = (opc == 4'hA) ? op[11:8] : op[7:4];
    e.rt   = (opc == 4'h9) ? op[11:8] : op[3:0];
    e.br   = (opc == 4'hC) && c;
    e.z    = mz;
    e.n    = mn;
    e.v    = mv;
    exp_q.push_back(e);

    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      got = exp_q.pop_front();
      check("result", bus.result, got.res);
      check("ctrl", 16'(bus.ctrl_signals), 16'(got.ctrl));
      check("rd", 16'(bus.rd), 16'(got.rd));
      check("rs", 16'(bus.rs), 16'(got.rs));
      check("rt", 16'(bus.rt), 16'(got.rt));
      check("br", 16'(bus.br), 16'(got.br));
      check("flags", 16'({bus.Z, bus.N, bus.V}), 16'({got.z, got.n, got.v}));
    end

    if (rst_n) begin
      mz = 1'b0; mn = 1'b0; mv = 1'b0;
    end else if (opc == 4'h0 || opc == 4'h2) begin
      mz = (r == 16'h0000);
      mn = r[15];
      mv = (raw > 32767) || (raw < -32768);
    end else if (opc >= 4'h3 && opc <= 4'h7) begin
      mz = (r == 16'h0000);
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.operation = 16'hC000;
    bus.input1    = 16'h0000;
    bus.input2    = 16'h0000;
    bus.pc        = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    mz = 1'b0; mn = 1'b0; mv = 1'b0;
    rst_n = 1'b0;

    step(16'hC200, 16'h0000, 16'h0000, 16'h0000);         // B EQ after reset: not taken
    step(16'hC000, 16'h0000, 16'h0000, 16'h0000);         // B NE: taken
    step(16'h0123, 16'h7FFF, 16'h0001, 16'h0000, 'h7FFF); // ADD saturates
    step(16'hCC00, 16'h0000, 16'h0000, 16'h0000);         // B OVFL: taken
    step(16'hC200, 16'h0000, 16'h0000, 16'h0000);         // B EQ on old Z
    step(16'h2123, 16'h0005, 16'h0005, 16'h0000, 'h0000); // SUB to zero
    step(16'hC200, 16'h0000, 16'h0000, 16'h0000);         // B EQ: taken
    step(16'h7104, 16'h8000, 16'h0000, 16'h0000, 'hF800); // SRA
    step(16'hA3AB, 16'h1234, 16'h0000, 16'h0000, 'hAB34); // LHB
    step(16'hD000, 16'h0000, 16'h0000, 16'h0010, 'h0011); // JAL
    step(16'hE050, 16'h0040, 16'h0000, 16'h0000, 'h0040); // JR
    step(16'hF000, 16'h0000, 16'h0000, 16'h0000, 'h0000); // HLT
    step(16'h1000, 16'h7F80, 16'h0180, 16'h0000, 'h7F80); // PADDSB both bytes saturate
    step(16'h9A3F, 16'h0010, 16'h0000, 16'h0000, 'h000F); // SW, rt from rd field
    step(16'h8123, 16'h0010, 16'h0000, 16'h0000, 'h0013); // LW
    step(16'hB0F0, 16'h0000, 16'h0000, 16'h0000, 'hFFF0); // LLB sign-extends
    step(16'h0000, 16'h8000, 16'hFFFF, 16'h0000, 'h8000); // ADD negative saturation
    step(16'hC600, 16'h0000, 16'h0000, 16'h0000);         // B LT: taken
    rst_n = 1'b1;
    step(16'h0000, 16'h7FFF, 16'h0001, 16'h0000);         // reset beats flag write
    rst_n = 1'b0;
    step(16'hCC00, 16'h0000, 16'h0000, 16'h0000);         // flags cleared

    for (int i = 0; i < 400; i++) begin
      logic [15:0] op, a, b;
      op = 16'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      case ($urandom_range(0, 5))
        0: a = 16'h7FFF;
        1: a = 16'h8000;
        2: b = a;
        default: ;
      endcase
      rst_n = ($urandom_range(0, 39) == 0);
      step(op, a, b, 16'($urandom));
    end
    rst_n = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
